dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_defs.sv | 17 +
 rtl/mem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared types for the data-memory responder: access size encoding and FSM state.
package mem_defs;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } rsp_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte-enables/replicated data, load extract and extend.
module mem_lane_align
    import mem_defs::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic signed [7:0]  rd_byte;
    logic signed [15:0] rd_half;

    assign rd_byte = rword[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Store data is replicated across lanes so the byte-enables alone pick the target.
    always_comb begin
        byte_en = 4'b0000;
        wword   = 32'h0;
        rdata   = 32'h0;
        case (size)
            BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                rdata   = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            HALF: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            WORD: begin
                byte_en = 4'b1111;
                wword   = wdata;
                rdata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
                wword   = 32'h0;
                rdata   = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable response latency.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module dmem_responder
    import mem_defs::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    rsp_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic        hold_write, hold_unsigned;
    logic [31:0] hold_addr, hold_wdata;
    mem_size_e   hold_size;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter_resp;
    logic        acc_write, acc_unsigned, acc_err, out_of_range, misalign;
    logic [31:0] acc_addr, acc_wdata, rd_word, wword, ld_data;
    mem_size_e   acc_size;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]  byte_en;

    assign accept = req_valid && (state_q == IDLE);

    // With LATENCY = 0 the access happens on the acceptance edge, before the holding registers load.
    assign acc_write    = (state_q == IDLE) ? req_write              : hold_write;
    assign acc_addr     = (state_q == IDLE) ? req_addr               : hold_addr;
    assign acc_size     = (state_q == IDLE) ? mem_size_e'(req_size)  : hold_size;
    assign acc_unsigned = (state_q == IDLE) ? req_unsigned           : hold_unsigned;
    assign acc_wdata    = (state_q == IDLE) ? req_wdata              : hold_wdata;

    assign acc_idx      = acc_addr[IDX_W+1:2];
    assign out_of_range = {2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((acc_size == HALF) && acc_addr[0]) ||
                      ((acc_size == WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign acc_err    = out_of_range || (acc_size == RSVD) || misalign;
    assign rd_word    = mem[acc_idx];
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    mem_lane_align u_align (
        .addr_lo     (acc_addr[1:0]),
        .size        (acc_size),
        .is_unsigned (acc_unsigned),
        .wdata       (acc_wdata),
        .rword       (rd_word),
        .byte_en     (byte_en),
        .wword       (wword),
        .rdata       (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rsp_rdata <= (acc_err || acc_write) ? 32'h0 : ld_data;
                rsp_err   <= acc_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_write    <= req_write;
            hold_addr     <= req_addr;
            hold_size     <= mem_size_e'(req_size);
            hold_unsigned <= req_unsigned;
            hold_wdata    <= req_wdata;
        end
    end

    // Gated by rst_n so a store caught by reset never commits.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS = 1024, LATENCY = 2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    // One full transaction; lat counts negedges after acceptance until rsp_valid is seen.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (rsp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL xact_timeout addr=%h got no rsp_valid, need one within 40 cycles", addr);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b need 0", rsp_valid); end
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got %h need 00000000", rsp_rdata); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b need 0", rsp_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b need 1", req_ready); end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL st_latency got %0d need 3", lat); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL st_err got %b need 0", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL st_rdata got %h need 00000000", rd); end
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL ld_latency got %0d need 3", lat); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b need 0", er); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_word got %h need deadbeef", rd); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h000080FF, rd, er, lat);
        xact(1'b1, 32'h44, 2'b10, 1'b0, 32'h00000000, rd, er, lat);
        xact(1'b1, 32'h00, 2'b10, 1'b0, 32'h5A5A5A5A, rd, er, lat);
        xact(1'b1, 32'h80, 2'b10, 1'b0, 32'h01234567, rd, er, lat);
        xact(1'b0, 32'h40, 2'b00, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL lb_signed got %h need ffffffff", rd); end
        xact(1'b0, 32'h40, 2'b00, 1'b1, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h000000FF) begin miscompares++; $display("FAIL lb_unsigned got %h need 000000ff", rd); end
        xact(1'b0, 32'h40, 2'b01, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_signed got %h need ffff80ff", rd); end
        xact(1'b0, 32'h40, 2'b01, 1'b1, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h000080FF) begin miscompares++; $display("FAIL lh_unsigned got %h need 000080ff", rd); end
        xact(1'b1, 32'h43, 2'b00, 1'b0, 32'hFFFFFF12, rd, er, lat);
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h120080FF) begin miscompares++; $display("FAIL sb_lane3 got %h need 120080ff", rd); end
        xact(1'b0, 32'h43, 2'b00, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h00000012) begin miscompares++; $display("FAIL lb_lane3 got %h need 00000012", rd); end
        xact(1'b0, 32'h42, 2'b01, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h00001200) begin miscompares++; $display("FAIL lh_upper got %h need 00001200", rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er; int lat; int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        // Keep a different request pending while the response is stalled.
        req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'hAAAAAAAA;
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        vectors++; if (rsp_rdata !== 32'h120080FF) begin miscompares++; $display("FAIL stall_rdata0 got %h need 120080ff", rsp_rdata); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %b need 1", i, rsp_valid); end
            vectors++; if (rsp_rdata !== 32'h120080FF) begin miscompares++; $display("FAIL stall_rdata[%0d] got %h need 120080ff", i, rsp_rdata); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_req_ready[%0d] got %b need 0", i, req_ready); end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release got %b need 0", rsp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_idle got %b need 1", req_ready); end
        xact(1'b0, 32'h44, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h00000000) begin miscompares++; $display("FAIL stall_no_second got %h need 00000000", rd); end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 32'h00001000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_ld_err got %b need 1", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_ld_rdata got %h need 00000000", rd); end
        xact(1'b1, 32'h00001000, 2'b10, 1'b0, 32'h11111111, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_st_err got %b need 1", er); end
        xact(1'b0, 32'h00000000, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL oor_no_alias got %h need 5a5a5a5a", rd); end
        xact(1'b0, 32'h40, 2'b11, 1'b0, 32'h0, rd, er, lat);
        vectors++; if ((er !== 1'b1) || (rd !== 32'h0)) begin miscompares++; $display("FAIL rsvd_size got err=%b rd=%h need err=1 rd=00000000", er, rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h41, 2'b01, 1'b0, 32'h0000BEEF, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL mis_sh_err got %b need 1", er); end
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h120080FF) begin miscompares++; $display("FAIL mis_sh_mem got %h need 120080ff", rd); end
        xact(1'b0, 32'h42, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if ((er !== 1'b1) || (rd !== 32'h0)) begin miscompares++; $display("FAIL mis_lw got err=%b rd=%h need err=1 rd=00000000", er, rd); end
`else
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL mis_sh_err got %b need 0", er); end
        xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h1200BEEF) begin miscompares++; $display("FAIL mis_sh_mem got %h need 1200beef", rd); end
        xact(1'b0, 32'h42, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if ((er !== 1'b0) || (rd !== 32'h1200BEEF)) begin miscompares++; $display("FAIL mis_lw got err=%b rd=%h need err=0 rd=1200beef", er, rd); end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 32'h80, 2'b10, 1'b0, 32'h0, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL abort_in_wait got req_ready=%b need 0", req_ready); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL abort_rdata got %h need 00000000", rsp_rdata); end
        vectors++; if ((rsp_valid !== 1'b0) || (rsp_err !== 1'b0)) begin miscompares++; $display("FAIL abort_outputs got valid=%b err=%b need 0/0", rsp_valid, rsp_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_req_ready got %b need 1", req_ready); end
        repeat (4) @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_rsp got %b need 0", rsp_valid); end
        xact(1'b0, 32'h80, 2'b10, 1'b0, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h01234567) begin miscompares++; $display("FAIL abort_mem got %h need 01234567", rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_stall();
        test_range();
        test_misalign();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
